snes_poll_scheduler: RTL and testbench
======================================

SNES_POLL_SCHEDULER -- requirements
Module: snes_poll_scheduler

Interface
REQ-001 Parameter TICK_DIV, default 162: the state machine advances one step every TICK_DIV+1 CLOCK cycles.
REQ-002 Parameter FRAME_DIV, default 833333: auto-poll period in CLOCK cycles (60 Hz at 50 MHz).
REQ-003 CLOCK  input  1  system clock, 50 MHz; the block has one clock.
REQ-004 RESET  input  1  reset, synchronous and active-high.
REQ-005 DATA1  input  1  serial data from controller port 1, active-low button.
REQ-006 DATA2  input  1  serial data from controller port 2, active-low button.
REQ-007 REQ  input  1  poll request level, held high until ACK.
REQ-008 AUTO_EN  input  1  enables periodic polling every FRAME_DIV cycles.
REQ-009 LATCH  output  1  shared latch line to both ports.
REQ-010 PULSE  output  1  shared clock line to both ports; idles high.
REQ-011 BUTTONS1  output  16  last complete port-1 word; bit k = serial bit k, 1 = pressed.
REQ-012 BUTTONS2  output  16  last complete port-2 word, same encoding.
REQ-013 PRESSED1, PRESSED2  output  16 each  rising-edge mask (new & ~old), valid with VALID.
REQ-014 VALID  output  1  one-cycle strobe when the BUTTONS/PRESSED outputs update.
REQ-015 ACK  output  1  one-cycle strobe completing a REQ-initiated poll.
REQ-016 BUSY  output  1  high in every state except IDLE.

Function
REQ-017 States: IDLE, LATCH, HIGH, LOW, DONE; a 4-bit bit counter k and a 2-bit latch counter.
REQ-018 Prescaler: counts 0..TICK_DIV, is cleared on entry to LATCH, and asserts tick when count == TICK_DIV; LATCH, HIGH and LOW change only on tick.
REQ-019 Frame counter: counts 0..FRAME_DIV-1 continuously while AUTO_EN=1, sets auto_pend at the wrap, and is cleared while AUTO_EN=0.
REQ-020 IDLE: LATCH=0, PULSE=1; if REQ or auto_pend, go to LATCH next cycle, record src_req=REQ, clear auto_pend.
REQ-021 LATCH: LATCH=1, PULSE=1 for exactly 2 ticks, then go to HIGH with k=0 and LATCH=0.
REQ-022 HIGH: PULSE=1; on tick, shift ~DATA1/~DATA2 into bit k of the shift registers, drive PULSE=0, go to LOW.
REQ-023 LOW: PULSE=0; on tick, drive PULSE=1; if k==15 go to DONE, else k=k+1 and go to HIGH.
REQ-024 DONE (one cycle): update BUTTONSn with the shift registers, compute PRESSEDn against the previous BUTTONSn, assert VALID, assert ACK if src_req, then go to IDLE.
REQ-025 A poll lasts 34 ticks plus 2 cycles (IDLE and DONE); all 16 bits are clocked per port, including bits 12..15.
REQ-026 A REQ or auto wrap arriving while BUSY is held pending (auto_pend, or the REQ level) and starts in the IDLE cycle after DONE; multiple auto wraps collapse into one.
REQ-027 REQ and auto_pend both present in IDLE: start one poll, src_req=1, and clear auto_pend; the single poll serves both.
REQ-028 If REQ drops before DONE, the poll completes normally and ACK is still asserted.
REQ-029 BUTTONS/PRESSED hold their values between DONE cycles; partial shifts are never visible on the outputs.

Reset
REQ-030 While RESET=1: state IDLE, prescaler/frame/bit counters 0, auto_pend 0, LATCH=0, PULSE=1, BUTTONS1/2=0, PRESSED1/2=0, VALID=0, ACK=0, BUSY=0.
REQ-031 RESET asserted mid-poll aborts the poll within one cycle with no VALID or ACK, and the outputs take their REQ-030 values.

Verification (TICK_DIV=1, FRAME_DIV=200)
REQ-032 REQ=1 with DATA1 low only during bit 0 and DATA2 always high -> LATCH high for 4 cycles, 16 PULSE low phases of 2 cycles, then BUTTONS1=0x0001, BUTTONS2=0x0000, VALID=ACK=1 for one cycle, 70 cycles after start.
REQ-033 Second poll with DATA1 low during bits 0 and 3 -> BUTTONS1=0x0009, PRESSED1=0x0008.
REQ-034 AUTO_EN=1, REQ=0 -> a poll starts every 200 cycles; VALID pulses and ACK stays 0.
REQ-035 REQ pulsed high during a poll, held until ACK -> a second poll starts the cycle after DONE, with exactly one ACK per poll.
REQ-036 RESET for one cycle at bit 7 -> the next cycle shows LATCH=0, PULSE=1, BUSY=0, BUTTONS=0, and no VALID pulse.
REQ-037 Random DATA streams across 100 polls -> BUTTONSn equals the bitwise inverse of the driven stream, and PULSE never toggles while LATCH=1.

Source files
------------

// File: rtl/snes_poll_if.sv
// Purpose: signal bundle between a poll requester / controller ports and the
//          SNES poll scheduler.
// Members:
//   DATA1, DATA2        serial data from controller ports (low = pressed)
//   REQ                 poll request level, held until ACK
//   AUTO_EN             enable periodic polling
//   LATCH, PULSE        shared latch and clock lines to both ports
//   BUTTONS1/2          last complete words, 1 = pressed
//   PRESSED1/2          rising-edge masks, valid with VALID
//   VALID, ACK, BUSY    update strobe, request completion strobe, busy flag
// Modports: master = requester/controller side, slave = scheduler.
interface snes_poll_if;
   logic        DATA1;
   logic        DATA2;
   logic        REQ;
   logic        AUTO_EN;
   logic        LATCH;
   logic        PULSE;
   logic [15:0] BUTTONS1;
   logic [15:0] BUTTONS2;
   logic [15:0] PRESSED1;
   logic [15:0] PRESSED2;
   logic        VALID;
   logic        ACK;
   logic        BUSY;

   modport master (
      output DATA1, DATA2, REQ, AUTO_EN,
      input  LATCH, PULSE, BUTTONS1, BUTTONS2, PRESSED1, PRESSED2, VALID, ACK, BUSY
   );

   modport slave (
      input  DATA1, DATA2, REQ, AUTO_EN,
      output LATCH, PULSE, BUTTONS1, BUTTONS2, PRESSED1, PRESSED2, VALID, ACK, BUSY
   );
endinterface

// File: rtl/snes_poll_scheduler.sv
// Purpose: polls two SNES controller ports on request or periodically,
//          clocking 16 bits from each and publishing the words with a
//          pressed-edge mask.
// Ports:
//   CLOCK  system clock
//   RESET  synchronous active-high reset
//   bus    snes_poll_if.slave: DATA1/2, REQ, AUTO_EN in; LATCH, PULSE,
//          BUTTONS1/2, PRESSED1/2, VALID, ACK, BUSY out (all registered)
module snes_poll_scheduler #(
   parameter int unsigned TICK_DIV  = 162,
   parameter int unsigned FRAME_DIV = 833333
) (
   input  logic        CLOCK,
   input  logic        RESET,
   snes_poll_if.slave  bus
);

   localparam int unsigned PW = (TICK_DIV > 0) ? $clog2(TICK_DIV + 1) : 1;
   localparam int unsigned FW = (FRAME_DIV > 1) ? $clog2(FRAME_DIV) : 1;

   typedef enum logic [2:0] {S_IDLE, S_LATCH, S_HIGH, S_LOW, S_DONE} state_t;

   state_t        state_q, state_d;
   logic [PW-1:0] presc_q, presc_d;
   logic [FW-1:0] frame_q, frame_d;
   logic          auto_pend_q, auto_pend_d;
   logic          src_req_q, src_req_d;
   logic [3:0]    bit_q, bit_d;
   logic [1:0]    lcnt_q, lcnt_d;
   logic [15:0]   sh1_q, sh1_d, sh2_q, sh2_d;
   logic [15:0]   btn1_q, btn1_d, btn2_q, btn2_d;
   logic [15:0]   prs1_q, prs1_d, prs2_q, prs2_d;
   logic          latch_q, latch_d, pulse_q, pulse_d;
   logic          valid_q, valid_d, ack_q, ack_d, busy_q, busy_d;

   logic tick_c;
   logic frame_wrap_c;

   assign tick_c       = (presc_q == PW'(TICK_DIV));
   assign frame_wrap_c = bus.AUTO_EN && (frame_q == FW'(FRAME_DIV - 1));

   // State register and all registered outputs
   always_ff @(posedge CLOCK) begin
      if (RESET) begin
         state_q     <= S_IDLE;
         presc_q     <= '0;
         frame_q     <= '0;
         auto_pend_q <= 1'b0;
         src_req_q   <= 1'b0;
         bit_q       <= '0;
         lcnt_q      <= '0;
         sh1_q       <= '0;
         sh2_q       <= '0;
         btn1_q      <= '0;
         btn2_q      <= '0;
         prs1_q      <= '0;
         prs2_q      <= '0;
         latch_q     <= 1'b0;
         pulse_q     <= 1'b1;
         valid_q     <= 1'b0;
         ack_q       <= 1'b0;
         busy_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         presc_q     <= presc_d;
         frame_q     <= frame_d;
         auto_pend_q <= auto_pend_d;
         src_req_q   <= src_req_d;
         bit_q       <= bit_d;
         lcnt_q      <= lcnt_d;
         sh1_q       <= sh1_d;
         sh2_q       <= sh2_d;
         btn1_q      <= btn1_d;
         btn2_q      <= btn2_d;
         prs1_q      <= prs1_d;
         prs2_q      <= prs2_d;
         latch_q     <= latch_d;
         pulse_q     <= pulse_d;
         valid_q     <= valid_d;
         ack_q       <= ack_d;
         busy_q      <= busy_d;
      end
   end

   // Next state, counters and output decode
   always_comb begin
      state_d     = state_q;
      presc_d     = tick_c ? '0 : PW'(presc_q + 1'b1);
      frame_d     = (!bus.AUTO_EN || frame_wrap_c) ? '0 : FW'(frame_q + 1'b1);
      auto_pend_d = auto_pend_q;
      src_req_d   = src_req_q;
      bit_d       = bit_q;
      lcnt_d      = lcnt_q;
      sh1_d       = sh1_q;
      sh2_d       = sh2_q;
      btn1_d      = btn1_q;
      btn2_d      = btn2_q;
      prs1_d      = prs1_q;
      prs2_d      = prs2_q;

      unique case (state_q)
         S_IDLE: begin
            if (bus.REQ || auto_pend_q) begin
               state_d     = S_LATCH;
               src_req_d   = bus.REQ;
               auto_pend_d = 1'b0;
               presc_d     = '0;
               lcnt_d      = '0;
            end
         end
         S_LATCH: begin
            if (tick_c) begin
               if (lcnt_q == 2'd1) begin
                  state_d = S_HIGH;
                  bit_d   = '0;
               end else begin
                  lcnt_d = 2'(lcnt_q + 2'd1);
               end
            end
         end
         S_HIGH: begin
            if (tick_c) begin
               sh1_d[bit_q] = ~bus.DATA1;
               sh2_d[bit_q] = ~bus.DATA2;
               state_d      = S_LOW;
            end
         end
         S_LOW: begin
            if (tick_c) begin
               if (bit_q == 4'd15) begin
                  // Publish on entry so the words are visible during DONE
                  state_d = S_DONE;
                  btn1_d  = sh1_q;
                  btn2_d  = sh2_q;
                  prs1_d  = sh1_q & ~btn1_q;
                  prs2_d  = sh2_q & ~btn2_q;
               end else begin
                  bit_d   = 4'(bit_q + 4'd1);
                  state_d = S_HIGH;
               end
            end
         end
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase

      // A wrap in the same cycle as a start is a fresh event and stays pending
      if (frame_wrap_c) auto_pend_d = 1'b1;

      latch_d = (state_d == S_LATCH);
      pulse_d = (state_d != S_LOW);
      busy_d  = (state_d != S_IDLE);
      valid_d = (state_d == S_DONE);
      ack_d   = (state_d == S_DONE) && src_req_q;
   end

   assign bus.LATCH    = latch_q;
   assign bus.PULSE    = pulse_q;
   assign bus.BUTTONS1 = btn1_q;
   assign bus.BUTTONS2 = btn2_q;
   assign bus.PRESSED1 = prs1_q;
   assign bus.PRESSED2 = prs2_q;
   assign bus.VALID    = valid_q;
   assign bus.ACK      = ack_q;
   assign bus.BUSY     = busy_q;

endmodule

// File: tb/tb_snes_poll_scheduler.sv
// Purpose: self-checking bench for snes_poll_scheduler with TICK_DIV=1 and
//          FRAME_DIV=200; a behavioural poll-timeline model checked every
//          cycle, plus literal checks on selected polls.
module tb_snes_poll_scheduler;
   localparam int TD       = 1;
   localparam int FD       = 200;
   // Position within a poll: 1..4 latch, 5..68 bit phases, 69 done
   localparam int DONE_POS = 69;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   snes_poll_if bus ();

   snes_poll_scheduler #(.TICK_DIV(TD), .FRAME_DIV(FD)) dut (
      .CLOCK (clk),
      .RESET (rst),
      .bus   (bus)
   );

   int          n_tests = 0;
   int          n_fail  = 0;
   logic [15:0] stream1 = 16'hFFFF;
   logic [15:0] stream2 = 16'hFFFF;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Controller model: bit 0 after latch, next bit on each PULSE rising edge
   int   idx = 0;
   logic prev_pulse = 1'b1;
   always @(negedge clk) begin
      if (bus.LATCH === 1'b1) idx = 0;
      else if (bus.PULSE === 1'b1 && prev_pulse === 1'b0) idx++;
      prev_pulse = bus.PULSE;
      bus.DATA1 = (idx < 16) ? stream1[idx[3:0]] : 1'b1;
      bus.DATA2 = (idx < 16) ? stream2[idx[3:0]] : 1'b1;
   end

   // Behavioural model: poll timeline by position, words from driven streams
   int          m_pos = 0, m_fc = 0;
   logic        m_pend = 1'b0, m_src = 1'b0, m_on = 1'b0;
   logic [15:0] m_b1 = '0, m_b2 = '0, m_p1 = '0, m_p2 = '0;
   initial begin
      forever begin
         @(posedge clk);
         if (rst) begin
            m_pos = 0; m_fc = 0; m_pend = 1'b0; m_src = 1'b0;
            m_b1 = '0; m_b2 = '0; m_p1 = '0; m_p2 = '0;
            m_on = 1'b1;
         end else begin
            logic wrap;
            wrap = bus.AUTO_EN && (m_fc == FD - 1);
            m_fc = (!bus.AUTO_EN || wrap) ? 0 : m_fc + 1;
            if (m_pos == 0) begin
               if (bus.REQ || m_pend) begin
                  m_pos = 1; m_src = bus.REQ; m_pend = 1'b0;
               end
            end else if (m_pos == DONE_POS) m_pos = 0;
            else m_pos++;
            if (m_pos == DONE_POS) begin
               m_p1 = ~stream1 & ~m_b1;
               m_p2 = ~stream2 & ~m_b2;
               m_b1 = ~stream1;
               m_b2 = ~stream2;
            end
            if (wrap) m_pend = 1'b1;
         end
         @(negedge clk);
         if (m_on) begin
            logic e_latch, e_pulse, e_busy, e_valid, e_ack;
            e_latch = (m_pos >= 1 && m_pos <= 4);
            e_pulse = !(m_pos >= 5 && m_pos < DONE_POS && ((m_pos - 5) % 4) >= 2);
            e_busy  = (m_pos != 0);
            e_valid = (m_pos == DONE_POS);
            e_ack   = e_valid && m_src;
            check("cycle latch/pulse/busy/valid/ack",
                  32'({bus.LATCH, bus.PULSE, bus.BUSY, bus.VALID, bus.ACK}),
                  32'({e_latch, e_pulse, e_busy, e_valid, e_ack}));
            check("cycle buttons2:1", {bus.BUTTONS2, bus.BUTTONS1}, {m_b2, m_b1});
            check("cycle pressed2:1", {bus.PRESSED2, bus.PRESSED1}, {m_p2, m_p1});
         end
      end
   end

   task automatic step();
      @(negedge clk);
   endtask

   // Wait for VALID, gathering line statistics; REQ dropped when ACK seen
   task automatic wait_valid(input int budget, output int n, output int lat,
                             output int low, output int falls, output logic acked);
      logic ok, prev;
      n = 0; lat = 0; low = 0; falls = 0; acked = 1'b0; ok = 1'b0; prev = 1'b1;
      while (n < budget && !ok) begin
         step();
         n++;
         if (bus.LATCH) lat++;
         if (!bus.PULSE) begin
            low++;
            if (prev) falls++;
         end
         prev = bus.PULSE;
         if (bus.ACK) begin
            acked = 1'b1;
            bus.REQ = 1'b0;
         end
         if (bus.VALID) ok = 1'b1;
      end
      check("wait_valid in budget", 32'(ok), 32'd1);
   endtask

   initial begin
      int   n, lat, low, falls, nv, na, first_v;
      logic acked, ok;
      rst = 1'b1;
      bus.REQ = 1'b0;
      bus.AUTO_EN = 1'b0;
      repeat (3) step();
      check("reset outputs", 32'({bus.LATCH, bus.PULSE, bus.BUSY, bus.VALID, bus.ACK}), 32'b01000);
      check("reset buttons", {bus.BUTTONS2, bus.BUTTONS1}, 32'h0);
      rst = 1'b0;
      step();

      // First poll: port 1 pressed on bit 0 only
      stream1 = 16'hFFFE; stream2 = 16'hFFFF;
      bus.REQ = 1'b1;
      wait_valid(200, n, lat, low, falls, acked);
      check("poll1 cycles to done", 32'(n), 32'd69);
      check("poll1 latch cycles", 32'(lat), 32'd4);
      check("poll1 pulse low cycles", 32'(low), 32'd32);
      check("poll1 pulse falls", 32'(falls), 32'd16);
      check("poll1 buttons1", 32'(bus.BUTTONS1), 32'h0001);
      check("poll1 buttons2", 32'(bus.BUTTONS2), 32'h0000);
      check("poll1 ack", 32'(acked), 32'd1);

      // Second poll: bits 0 and 3
      step();
      stream1 = 16'hFFF6;
      bus.REQ = 1'b1;
      wait_valid(200, n, lat, low, falls, acked);
      check("poll2 buttons1", 32'(bus.BUTTONS1), 32'h0009);
      check("poll2 pressed1", 32'(bus.PRESSED1), 32'h0008);

      // REQ dropped early still gets ACK
      step();
      stream1 = 16'h5A5A; stream2 = 16'h0F0F;
      bus.REQ = 1'b1;
      step();
      bus.REQ = 1'b0;
      wait_valid(200, n, lat, low, falls, acked);
      check("early drop ack", 32'(acked), 32'd1);
      check("early drop buttons", {bus.BUTTONS2, bus.BUTTONS1}, 32'hF0F0A5A5);

      // Auto polling: one poll per 200 cycles, no ACK
      step();
      bus.AUTO_EN = 1'b1;
      nv = 0; na = 0; first_v = -1;
      for (int i = 1; i <= 700; i++) begin
         step();
         if (bus.VALID) begin
            nv++;
            if (first_v < 0) first_v = i;
         end
         if (bus.ACK) na++;
      end
      check("auto first valid cycle", 32'(first_v), 32'd269);
      check("auto valid count", 32'(nv), 32'd3);
      check("auto ack count", 32'(na), 32'd0);

      // REQ raised during an auto poll starts a second poll after DONE
      ok = 1'b0;
      for (int i = 0; i < 300 && !ok; i++) begin
         step();
         if (bus.BUSY && bus.LATCH) ok = 1'b1;
      end
      check("auto poll started", 32'(ok), 32'd1);
      bus.AUTO_EN = 1'b0;
      repeat (20) step();
      bus.REQ = 1'b1;
      wait_valid(200, n, lat, low, falls, acked);
      check("auto poll no ack", 32'(acked), 32'd0);
      step();
      check("idle after done", 32'({bus.BUSY, bus.LATCH}), 32'b00);
      step();
      check("back-to-back start", 32'({bus.BUSY, bus.LATCH}), 32'b11);
      wait_valid(200, n, lat, low, falls, acked);
      check("second poll ack", 32'(acked), 32'd1);

      // Reset at bit 7 aborts the poll
      step();
      stream1 = 16'h1234; stream2 = 16'h4321;
      bus.REQ = 1'b1;
      ok = 1'b0;
      for (int i = 0; i < 200 && !ok; i++) begin
         step();
         if (idx == 7 && !bus.LATCH) ok = 1'b1;
      end
      check("reached bit 7", 32'(ok), 32'd1);
      rst = 1'b1;
      bus.REQ = 1'b0;
      step();
      check("abort outputs", 32'({bus.LATCH, bus.PULSE, bus.BUSY, bus.VALID, bus.ACK}), 32'b01000);
      check("abort buttons", {bus.BUTTONS2, bus.BUTTONS1}, 32'h0);
      rst = 1'b0;
      nv = 0;
      repeat (100) begin
         step();
         if (bus.VALID) nv++;
      end
      check("no valid after abort", 32'(nv), 32'd0);

      // Random streams
      for (int p = 0; p < 100; p++) begin
         stream1 = 16'($urandom);
         stream2 = 16'($urandom);
         bus.REQ = 1'b1;
         wait_valid(200, n, lat, low, falls, acked);
         check("random buttons", {bus.BUTTONS2, bus.BUTTONS1}, {~stream2, ~stream1});
         step();
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
